// File: rtl/pipe_pkg.sv
// Shared types and constants for the 4-stage pipeline sequencer.
package pipe_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int PH_IF = 0;
  localparam int PH_ID = 1;
  localparam int PH_EX = 2;
  localparam int PH_WB = 3;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the CPU datapath and the pipeline sequencer.
interface pipe_ctrl_if #(
  parameter int RBITS = 3,
  parameter int CW    = 16
);
  logic             start;
  logic             stop;
  logic [RBITS-1:0] id_rs1;
  logic [RBITS-1:0] id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [RBITS-1:0] ex_rd;
  logic             ex_we;
  logic [RBITS-1:0] wb_rd;
  logic             wb_we;
  logic             wb_taken;
  logic [3:0]       ph;
  logic             busy;
  logic             stall;
  logic             flush;
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    flush_cnt;

  modport master (
    output start, stop, id_rs1, id_rs2, id_use1, id_use2,
           ex_rd, ex_we, wb_rd, wb_we, wb_taken,
    input  ph, busy, stall, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, stop, id_rs1, id_rs2, id_use1, id_use2,
           ex_rd, ex_we, wb_rd, wb_we, wb_taken,
    output ph, busy, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// RAW comparator: the ID instruction must wait while an older valid stage will
// still write one of its sources (no bypass; WB writes on the operand-latch edge).
module hazard_unit #(
  parameter int RBITS = 3
) (
  input  logic                  v_id_i,
  input  logic                  v_ex_i,
  input  logic                  v_wb_i,
  input  logic [1:0][RBITS-1:0] rs_i,
  input  logic [1:0]            use_i,
  input  logic [RBITS-1:0]      ex_rd_i,
  input  logic                  ex_we_i,
  input  logic [RBITS-1:0]      wb_rd_i,
  input  logic                  wb_we_i,
  output logic                  hazard_o
);
  logic [1:0] hit;

  for (genvar s = 0; s < 2; s++) begin : g_src
    assign hit[s] = use_i[s] &
                    ((v_ex_i & ex_we_i & (rs_i[s] == ex_rd_i)) |
                     (v_wb_i & wb_we_i & (rs_i[s] == wb_rd_i)));
  end

  assign hazard_o = v_id_i & (|hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage valid tracking, RAW stall bubbles, branch
// flush, run/stop with drain, and stall/flush performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int RBITS = 3,
  parameter int CW    = 16
) (
  input logic        CLK,
  input logic        RST,
  pipe_ctrl_if.slave bus
);
  state_e                 state_q, state_d;
  logic [PH_WB:PH_ID]     vld_q, vld_d;
  logic [CW-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]          flush_cnt_q, flush_cnt_d;
  logic                   hazard, stall, flush, run_start;
  logic [3:0]             ph;

  hazard_unit #(.RBITS(RBITS)) u_hazard (
    .v_id_i   (vld_q[PH_ID]),
    .v_ex_i   (vld_q[PH_EX]),
    .v_wb_i   (vld_q[PH_WB]),
    .rs_i     ({bus.id_rs2, bus.id_rs1}),
    .use_i    ({bus.id_use2, bus.id_use1}),
    .ex_rd_i  (bus.ex_rd),
    .ex_we_i  (bus.ex_we),
    .wb_rd_i  (bus.wb_rd),
    .wb_we_i  (bus.wb_we),
    .hazard_o (hazard)
  );

  // A retiring taken branch owns the PC this cycle, so it overrides any stall.
  assign flush = vld_q[PH_WB] & bus.wb_taken;
  assign stall = hazard & ~flush;

  always_comb begin
    ph        = '0;
    ph[PH_IF] = (state_q == RUN) & ~stall & ~flush;
    ph[PH_ID] = vld_q[PH_ID] & ~stall & ~flush;
    ph[PH_EX] = vld_q[PH_EX] & ~flush;
    ph[PH_WB] = vld_q[PH_WB];
  end

  // Valid bits shift along with the enables; a stall holds ID and injects a bubble into EX.
  always_comb begin
    vld_d = '0;
    if (!flush) begin
      vld_d[PH_WB] = ph[PH_EX];
      vld_d[PH_EX] = ph[PH_ID];
      vld_d[PH_ID] = stall ? vld_q[PH_ID] : ph[PH_IF];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start && !bus.stop) state_d = RUN;
      RUN:     if (bus.stop)               state_d = DRAIN;
      DRAIN:   if (vld_d == '0)            state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  assign run_start = (state_q == IDLE) && (state_d == RUN);

  always_comb begin
    stall_cnt_d = stall_cnt_q + CW'(stall);
    flush_cnt_d = flush_cnt_q + CW'(flush);
    if (run_start) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    bus.ph        = ph;
    bus.busy      = (state_q != IDLE);
    bus.stall     = stall;
    bus.flush     = flush;
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, then random stimulus
// against a stage-occupancy reference model.
module tb_pipe_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  pipe_ctrl_if #(.RBITS(3), .CW(16)) bus ();

  pipe_ctrl #(.RBITS(3), .CW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit       rst, start, stop, tk;
    bit       use1, use2, ex_we, wb_we;
    bit [2:0] rs1, rs2, exrd, wbrd;
    bit [3:0] ph;
    bit       busy, stall, flush;
    int       sc, fc;
  } vec_t;

  function automatic vec_t row(input bit rst, start, stop, tk, input bit [3:0] ph,
                               input bit busy, stall, flush, input int sc, fc);
    vec_t v;
    v = '{default: '0};
    v.rst = rst; v.start = start; v.stop = stop; v.tk = tk;
    v.ph = ph; v.busy = busy; v.stall = stall; v.flush = flush;
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic drive(input bit rst, start, stop, tk, use1, use2, ex_we, wb_we,
                       input bit [2:0] rs1, rs2, exrd, wbrd);
    RST = rst; bus.start = start; bus.stop = stop; bus.wb_taken = tk;
    bus.id_use1 = use1; bus.id_use2 = use2; bus.ex_we = ex_we; bus.wb_we = wb_we;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.ex_rd = exrd; bus.wb_rd = wbrd;
  endtask

  // Reference model: mode 0=idle 1=run 2=drain; occupancy per stage.
  int       m_mode = 0;
  bit       m_id = 0, m_ex = 0, m_wb = 0;
  bit [15:0] m_sc = 0, m_fc = 0;

  function automatic bit blocked(input bit use_it, input bit [2:0] rs);
    bit b;
    b = 1'b0;
    if (use_it) begin
      if (m_ex && bus.ex_we && bus.ex_rd == rs) b = 1'b1;
      if (m_wb && bus.wb_we && bus.wb_rd == rs) b = 1'b1;
    end
    return b;
  endfunction

  vec_t tbl[32];

  initial begin
    bus.start = 0; bus.stop = 0; bus.wb_taken = 0;
    bus.id_use1 = 0; bus.id_use2 = 0; bus.ex_we = 0; bus.wb_we = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rd = 0; bus.wb_rd = 0;

    tbl[0]  = row(1,0,0,0, 4'b0000, 0,0,0, 0,0);
    tbl[1]  = row(0,1,0,0, 4'b0000, 0,0,0, 0,0);
    tbl[2]  = row(0,0,0,0, 4'b0001, 1,0,0, 0,0);
    tbl[3]  = row(0,0,0,0, 4'b0011, 1,0,0, 0,0);
    tbl[4]  = row(0,0,0,0, 4'b0111, 1,0,0, 0,0);
    tbl[5]  = row(0,0,0,0, 4'b1111, 1,0,0, 0,0);
    tbl[6]  = row(0,0,0,0, 4'b1100, 1,1,0, 0,0);
    tbl[6].use1 = 1; tbl[6].rs1 = 3; tbl[6].ex_we = 1; tbl[6].exrd = 3;
    tbl[7]  = row(0,0,0,0, 4'b1000, 1,1,0, 1,0);
    tbl[7].use1 = 1; tbl[7].rs1 = 3; tbl[7].wb_we = 1; tbl[7].wbrd = 3;
    tbl[8]  = row(0,0,0,0, 4'b0011, 1,0,0, 2,0);
    tbl[8].use1 = 1; tbl[8].rs1 = 3;
    tbl[9]  = row(0,0,0,0, 4'b0111, 1,0,0, 2,0);
    tbl[10] = row(0,0,0,0, 4'b1100, 1,1,0, 2,0);
    tbl[10].use2 = 1; tbl[10].rs2 = 5; tbl[10].wb_we = 1; tbl[10].wbrd = 5;
    tbl[11] = row(0,0,0,0, 4'b1011, 1,0,0, 3,0);
    tbl[12] = row(0,0,0,0, 4'b0111, 1,0,0, 3,0);
    tbl[13] = row(0,0,0,0, 4'b1111, 1,0,0, 3,0);
    tbl[14] = row(0,0,0,1, 4'b1000, 1,0,1, 3,0);
    tbl[14].use1 = 1; tbl[14].rs1 = 2; tbl[14].ex_we = 1; tbl[14].exrd = 2;
    tbl[15] = row(0,0,0,0, 4'b0001, 1,0,0, 3,1);
    tbl[16] = row(0,0,0,0, 4'b0011, 1,0,0, 3,1);
    tbl[17] = row(0,0,0,0, 4'b0111, 1,0,0, 3,1);
    tbl[18] = row(0,0,0,0, 4'b1111, 1,0,0, 3,1);
    tbl[19] = row(0,0,1,0, 4'b1111, 1,0,0, 3,1);
    tbl[20] = row(0,1,0,0, 4'b1110, 1,0,0, 3,1);
    tbl[21] = row(0,0,0,0, 4'b1100, 1,0,0, 3,1);
    tbl[22] = row(0,0,0,0, 4'b1000, 1,0,0, 3,1);
    tbl[23] = row(0,0,0,0, 4'b0000, 0,0,0, 3,1);
    tbl[24] = row(0,1,1,0, 4'b0000, 0,0,0, 3,1);
    tbl[25] = row(0,0,0,0, 4'b0000, 0,0,0, 3,1);
    tbl[26] = row(0,1,0,0, 4'b0000, 0,0,0, 3,1);
    tbl[27] = row(0,0,0,0, 4'b0001, 1,0,0, 0,0);
    tbl[28] = row(0,0,0,0, 4'b0011, 1,0,0, 0,0);
    tbl[29] = row(0,0,0,0, 4'b0100, 1,1,0, 0,0);
    tbl[29].use1 = 1; tbl[29].rs1 = 1; tbl[29].ex_we = 1; tbl[29].exrd = 1;
    tbl[30] = row(1,0,0,0, 4'b1011, 1,0,0, 1,0);
    tbl[31] = row(0,0,0,0, 4'b0000, 0,0,0, 0,0);

    // Unchecked reset cycle to bring the design out of its power-up state.
    @(negedge CLK);

    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].tk, tbl[i].use1, tbl[i].use2,
            tbl[i].ex_we, tbl[i].wb_we, tbl[i].rs1, tbl[i].rs2, tbl[i].exrd, tbl[i].wbrd);
      #1;
      chk($sformatf("vec%0d ph", i), 32'(bus.ph), 32'(tbl[i].ph));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(tbl[i].stall));
      chk($sformatf("vec%0d flush", i), 32'(bus.flush), 32'(tbl[i].flush));
      chk($sformatf("vec%0d stall_cnt", i), 32'(bus.stall_cnt), 32'(tbl[i].sc));
      chk($sformatf("vec%0d flush_cnt", i), 32'(bus.flush_cnt), 32'(tbl[i].fc));
    end

    // Random phase: model starts idle, empty, counters zero (left so by the table).
    for (int c = 0; c < 3000; c++) begin
      bit haz, e_flush, e_stall, fetch, issue, adv, nid, nex, nwb, rst;
      bit [3:0] e_ph;
      @(negedge CLK);
      rst = ($urandom_range(0, 99) == 0);
      drive(rst, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      #1;
      haz     = m_id && (blocked(bus.id_use1, bus.id_rs1) || blocked(bus.id_use2, bus.id_rs2));
      e_flush = m_wb && bus.wb_taken;
      e_stall = haz && !e_flush;
      fetch   = (m_mode == 1) && !e_stall && !e_flush;
      issue   = m_id && !e_stall && !e_flush;
      adv     = m_ex && !e_flush;
      e_ph    = {m_wb, adv, issue, fetch};
      chk($sformatf("rnd%0d ph", c), 32'(bus.ph), 32'(e_ph));
      chk($sformatf("rnd%0d busy", c), 32'(bus.busy), 32'(m_mode != 0));
      chk($sformatf("rnd%0d stall", c), 32'(bus.stall), 32'(e_stall));
      chk($sformatf("rnd%0d flush", c), 32'(bus.flush), 32'(e_flush));
      chk($sformatf("rnd%0d stall_cnt", c), 32'(bus.stall_cnt), 32'(m_sc));
      chk($sformatf("rnd%0d flush_cnt", c), 32'(bus.flush_cnt), 32'(m_fc));

      if (rst) begin
        m_mode = 0; m_id = 0; m_ex = 0; m_wb = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (e_flush) begin
          nid = 0; nex = 0; nwb = 0;
          m_fc = m_fc + 16'd1;
        end else begin
          nwb = adv;
          nex = issue;
          nid = e_stall ? m_id : fetch;
          if (e_stall) m_sc = m_sc + 16'd1;
        end
        case (m_mode)
          0: if (bus.start && !bus.stop) begin m_mode = 1; m_sc = 0; m_fc = 0; end
          1: if (bus.stop) m_mode = 2;
          default: if (!nid && !nex && !nwb) m_mode = 0;
        endcase
        m_id = nid; m_ex = nex; m_wb = nwb;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
